rv32m_divider: RTL

- Sequential radix-2 restoring divider for the RV32M execute stage.
- Implements DIV, DIVU, REM and REMU with a start/ready handshake and one quotient bit per cycle.
- Sits beside the Booth multiplier in the M-extension datapath; the hazard unit stalls the pipeline while busy is high.
- Returns the RISC-V-mandated results for divide-by-zero and signed overflow without iterating.

---
 rtl/rv32m_divider.sv | 106 ++++++++++
 1 files changed

// File: rtl/rv32m_divider.sv
// rv32m_divider: sequential radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU
module rv32m_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       div_opcode,
    input  logic             flush,
    input  logic [WIDTH-1:0] operand1,
    input  logic [WIDTH-1:0] operand2,
    output logic [WIDTH-1:0] result,
    output logic             ready,
    output logic             busy
);
    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [WIDTH-1:0] MIN = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t           state;
    logic [1:0]       op;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] divisor;
    logic [WIDTH:0]   rem;
    logic [CW-1:0]    counter;
    logic             q_neg;
    logic             r_neg;
    logic             dz;
    logic             ovf;
    logic             is_signed;
    logic             start_dz;
    logic             start_ovf;
    logic [WIDTH-1:0] abs1;
    logic [WIDTH-1:0] abs2;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] fix_val;

    assign busy = state != IDLE;

    // Operand conditioning, one restoring step, and final sign/special-case selection
    always_comb begin
        is_signed = !div_opcode[0];
        start_dz  = operand2 == '0;
        start_ovf = is_signed && operand1 == MIN && operand2 == '1;
        abs1      = (is_signed && operand1[WIDTH-1]) ? -operand1 : operand1;
        abs2      = (is_signed && operand2[WIDTH-1]) ? -operand2 : operand2;
        shifted   = {rem[WIDTH-1:0], quo[WIDTH-1]};
        trial     = shifted - {1'b0, divisor};
        fix_val   = dz  ? (op[1] ? quo : '1) :
                    ovf ? (op[1] ? '0 : MIN) :
                    op[1] ? (r_neg ? -rem[WIDTH-1:0] : rem[WIDTH-1:0]) :
                            (q_neg ? -quo : quo);
    end

    // Control FSM and datapath; quo holds the raw dividend in the divide-by-zero case
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            result  <= '0;
            ready   <= 1'b0;
            counter <= '0;
            op      <= '0;
            quo     <= '0;
            divisor <= '0;
            rem     <= '0;
            q_neg   <= 1'b0;
            r_neg   <= 1'b0;
            dz      <= 1'b0;
            ovf     <= 1'b0;
        end else begin
            ready <= 1'b0;
            case (state)
                IDLE: if (start && !flush) begin
                    op      <= div_opcode;
                    quo     <= start_dz ? operand1 : abs1;
                    divisor <= abs2;
                    rem     <= '0;
                    counter <= '0;
                    q_neg   <= is_signed && (operand1[WIDTH-1] ^ operand2[WIDTH-1]);
                    r_neg   <= is_signed && operand1[WIDTH-1];
                    dz      <= start_dz;
                    ovf     <= start_ovf;
                    state   <= (start_dz || start_ovf) ? FIX : CALC;
                end
                CALC: if (flush) begin
                    state <= IDLE;
                end else begin
                    rem     <= trial[WIDTH] ? shifted : trial;
                    quo     <= {quo[WIDTH-2:0], !trial[WIDTH]};
                    counter <= counter + CW'(1);
                    if (counter == CW'(WIDTH - 1)) state <= FIX;
                end
                FIX: begin
                    state <= IDLE;
                    if (!flush) begin
                        result <= fix_val;
                        ready  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
